// File: rtl/conv_computation_module.sv
// 2-D valid correlation of a 4x4 image with a 3x3 kernel into a 2x2 result.
// Three interchangeable datapaths: single MAC, 3-PE and 2-PE systolic arrays.
module conv_computation_module #(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          active_send,
    input  logic          active_single,
    input  logic          active_sa3,
    input  logic          active_sa2,
    input  logic [DW-1:0] a11, a12, a13, a14,
    input  logic [DW-1:0] a21, a22, a23, a24,
    input  logic [DW-1:0] a31, a32, a33, a34,
    input  logic [DW-1:0] a41, a42, a43, a44,
    input  logic [DW-1:0] b11, b12, b13,
    input  logic [DW-1:0] b21, b22, b23,
    input  logic [DW-1:0] b31, b32, b33,
    output logic [DW-1:0] c11, c12, c21, c22,
    output logic          done_send,
    output logic          done_single,
    output logic          done_sa3,
    output logic          done_sa2
);

    localparam logic [5:0] N_SINGLE = 6'd36;
    localparam logic [4:0] N_SA3    = 5'd16;
    localparam logic [4:0] N_SA2    = 5'd28;

    logic [DW-1:0] a_in [4][4];
    logic [DW-1:0] b_in [3][3];
    logic [DW-1:0] a_r  [4][4];
    logic [DW-1:0] b_r  [3][3];

    assign a_in = '{'{a11, a12, a13, a14}, '{a21, a22, a23, a24},
                    '{a31, a32, a33, a34}, '{a41, a42, a43, a44}};
    assign b_in = '{'{b11, b12, b13}, '{b21, b22, b23}, '{b31, b32, b33}};

    // Mode priority: send > single > sa3 > sa2
    logic run_single, run_sa3, run_sa2;
    assign run_single = active_single & ~active_send;
    assign run_sa3    = active_sa3 & ~active_send & ~active_single;
    assign run_sa2    = active_sa2 & ~active_send & ~active_single & ~active_sa3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r       <= '{default: '0};
            b_r       <= '{default: '0};
            done_send <= 1'b0;
        end else begin
            done_send <= active_send;
            if (active_send) begin
                a_r <= a_in;
                b_r <= b_in;
            end
        end
    end

    // Single MAC: step k -> output k/9, tap k%9
    logic [5:0]      s_cnt;
    logic [1:0]      s_o, s_r, s_s;
    logic [2*DW-1:0] s_prod;
    logic [ACCW-1:0] s_acc [4];

    always_comb begin
        s_o    = 2'(s_cnt / 6'd9);
        s_r    = 2'((s_cnt % 6'd9) / 6'd3);
        s_s    = 2'(s_cnt % 6'd3);
        s_prod = a_r[{1'b0, s_o[1]} + s_r][{1'b0, s_o[0]} + s_s] * b_r[s_r][s_s];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_cnt       <= '0;
            s_acc       <= '{default: '0};
            done_single <= 1'b0;
        end else if (!run_single) begin
            s_cnt       <= '0;
            s_acc       <= '{default: '0};
            done_single <= 1'b0;
        end else if (s_cnt != N_SINGLE) begin
            s_cnt      <= s_cnt + 6'd1;
            s_acc[s_o] <= s_acc[s_o] + ACCW'(s_prod);
            if (s_cnt == N_SINGLE - 6'd1)
                done_single <= 1'b1;
        end
    end

    // 3-PE array: PE s holds kernel column s, fed one cycle later than PE s-1
    logic [4:0]      t_cnt;
    logic [4:0]      t_m    [3];
    logic            t_v    [3];
    logic [1:0]      t_o    [3];
    logic [1:0]      t_r    [3];
    logic [2*DW-1:0] t_prod [3];
    logic [ACCW-1:0] p3_acc [3][4];

    always_comb begin
        for (int unsigned s = 0; s < 3; s++) begin
            t_m[s]    = t_cnt - 5'(s);
            t_v[s]    = (t_cnt >= 5'(s)) && (t_m[s] < 5'd12);
            t_o[s]    = 2'(t_m[s] / 5'd3);
            t_r[s]    = 2'(t_m[s] % 5'd3);
            t_prod[s] = a_r[{1'b0, t_o[s][1]} + t_r[s]][{1'b0, t_o[s][0]} + 2'(s)]
                        * b_r[t_r[s]][2'(s)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_cnt    <= '0;
            p3_acc   <= '{default: '0};
            done_sa3 <= 1'b0;
        end else if (!run_sa3) begin
            t_cnt    <= '0;
            p3_acc   <= '{default: '0};
            done_sa3 <= 1'b0;
        end else if (t_cnt != N_SA3) begin
            t_cnt <= t_cnt + 5'd1;
            for (int unsigned s = 0; s < 3; s++)
                if (t_v[s])
                    p3_acc[2'(s)][t_o[s]] <= p3_acc[2'(s)][t_o[s]] + ACCW'(t_prod[s]);
            if (t_cnt == N_SA3 - 5'd1)
                done_sa3 <= 1'b1;
        end
    end

    // 2-PE array: PE j owns output column j, skewed by one cycle
    logic [4:0]      q_cnt;
    logic [4:0]      q_m    [2];
    logic            q_v    [2];
    logic            q_i    [2];
    logic [1:0]      q_r    [2];
    logic [1:0]      q_s    [2];
    logic [2*DW-1:0] q_prod [2];
    logic [ACCW-1:0] q_acc  [2][2];

    always_comb begin
        for (int unsigned j = 0; j < 2; j++) begin
            q_m[j]    = q_cnt - 5'(j);
            q_v[j]    = (q_cnt >= 5'(j)) && (q_m[j] < 5'd18);
            q_i[j]    = (q_m[j] >= 5'd9);
            q_r[j]    = 2'((q_m[j] % 5'd9) / 5'd3);
            q_s[j]    = 2'(q_m[j] % 5'd3);
            q_prod[j] = a_r[{1'b0, q_i[j]} + q_r[j]][2'(j) + q_s[j]] * b_r[q_r[j]][q_s[j]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_cnt    <= '0;
            q_acc    <= '{default: '0};
            done_sa2 <= 1'b0;
        end else if (!run_sa2) begin
            q_cnt    <= '0;
            q_acc    <= '{default: '0};
            done_sa2 <= 1'b0;
        end else if (q_cnt != N_SA2) begin
            q_cnt <= q_cnt + 5'd1;
            for (int unsigned j = 0; j < 2; j++)
                if (q_v[j])
                    q_acc[1'(j)][q_i[j]] <= q_acc[1'(j)][q_i[j]] + ACCW'(q_prod[j]);
            if (q_cnt == N_SA2 - 5'd1)
                done_sa2 <= 1'b1;
        end
    end

    // Final sums; the single MAC folds in its last product on the completing edge
    logic [ACCW-1:0] fin [4];
    logic            fin_en;

    always_comb begin
        fin_en = 1'b0;
        fin    = '{default: '0};
        if (run_single && s_cnt == N_SINGLE - 6'd1) begin
            fin_en = 1'b1;
            for (int unsigned k = 0; k < 4; k++)
                fin[k] = s_acc[k] + ((2'(k) == s_o) ? ACCW'(s_prod) : '0);
        end else if (run_sa3 && t_cnt == N_SA3 - 5'd1) begin
            fin_en = 1'b1;
            for (int unsigned k = 0; k < 4; k++)
                fin[k] = p3_acc[0][k] + p3_acc[1][k] + p3_acc[2][k];
        end else if (run_sa2 && q_cnt == N_SA2 - 5'd1) begin
            fin_en = 1'b1;
            for (int unsigned k = 0; k < 4; k++)
                fin[k] = q_acc[1'(k % 2)][1'(k / 2)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c11 <= '0;
            c12 <= '0;
            c21 <= '0;
            c22 <= '0;
        end else if (fin_en) begin
            c11 <= fin[0][DW-1:0];
            c12 <= fin[1][DW-1:0];
            c21 <= fin[2][DW-1:0];
            c22 <= fin[3][DW-1:0];
        end
    end

endmodule

// File: tb/tb_conv_computation_module.sv
// Directed bench for conv_computation_module: vector table over all three modes
// plus abort, priority and mid-run reset sequences.
module tb_conv_computation_module;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       active_send = 1'b0, active_single = 1'b0, active_sa3 = 1'b0, active_sa2 = 1'b0;
    logic [7:0] a_p [16];
    logic [7:0] b_p [9];
    logic [7:0] c11, c12, c21, c22;
    logic       done_send, done_single, done_sa3, done_sa2;
    logic [31:0] c_all;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0][7:0] a;
        logic [8:0][7:0]  b;
        logic [3:0][7:0]  c;   // [0]=c11 [1]=c12 [2]=c21 [3]=c22
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    assign c_all = {c22, c21, c12, c11};

    conv_computation_module #(.DW(8), .ACCW(20)) dut (
        .clk(clk), .rst(rst),
        .active_send(active_send), .active_single(active_single),
        .active_sa3(active_sa3), .active_sa2(active_sa2),
        .a11(a_p[0]),  .a12(a_p[1]),  .a13(a_p[2]),  .a14(a_p[3]),
        .a21(a_p[4]),  .a22(a_p[5]),  .a23(a_p[6]),  .a24(a_p[7]),
        .a31(a_p[8]),  .a32(a_p[9]),  .a33(a_p[10]), .a34(a_p[11]),
        .a41(a_p[12]), .a42(a_p[13]), .a43(a_p[14]), .a44(a_p[15]),
        .b11(b_p[0]), .b12(b_p[1]), .b13(b_p[2]),
        .b21(b_p[3]), .b22(b_p[4]), .b23(b_p[5]),
        .b31(b_p[6]), .b32(b_p[7]), .b33(b_p[8]),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .done_send(done_send), .done_single(done_single),
        .done_sa3(done_sa3), .done_sa2(done_sa2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int m);
        case (m)
            0:       return done_single;
            1:       return done_sa3;
            default: return done_sa2;
        endcase
    endfunction

    task automatic set_mode(input int m, input logic v);
        case (m)
            0:       active_single = v;
            1:       active_sa3    = v;
            default: active_sa2    = v;
        endcase
    endtask

    task automatic send_vec(input vec_t v, input logic [31:0] c_before);
        for (int k = 0; k < 16; k++) a_p[k] = v.a[k];
        for (int k = 0; k < 9; k++)  b_p[k] = v.b[k];
        active_send = 1'b1;
        tick();
        check("done_send set", 32'(done_send), 32'd1);
        active_send = 1'b0;
        for (int k = 0; k < 16; k++) a_p[k] = 8'hA5;
        for (int k = 0; k < 9; k++)  b_p[k] = 8'h5A;
        tick();
        check("done_send clear", 32'(done_send), 32'd0);
        check("c unchanged by send", c_all, c_before);
    endtask

    task automatic run_mode(input int m, input logic [31:0] exp_c, input string tag);
        int n;
        n = (m == 0) ? 36 : (m == 1) ? 16 : 28;
        set_mode(m, 1'b1);
        repeat (n - 1) tick();
        check({tag, " done early"}, 32'(done_of(m)), 32'd0);
        tick();
        check({tag, " done at N"}, 32'(done_of(m)), 32'd1);
        check({tag, " result"}, c_all, exp_c);
        tick();
        check({tag, " done hold"}, 32'(done_of(m)), 32'd1);
        check({tag, " result hold"}, c_all, exp_c);
        set_mode(m, 1'b0);
        tick();
        check({tag, " done drop"}, 32'(done_of(m)), 32'd0);
        check({tag, " result kept"}, c_all, exp_c);
    endtask

    initial begin
        vec_t v;
        string mname [3];
        mname = '{"single", "sa3", "sa2"};

        // v0: A rows [1 2 3 4], B rows all 1 / 2 / 3
        v = '0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) v.a[r*4+c] = 8'(c + 1);
        for (int r = 0; r < 3; r++) for (int s = 0; s < 3; s++) v.b[r*3+s] = 8'(r + 1);
        v.c = {8'd54, 8'd36, 8'd54, 8'd36};
        vecs[0] = v;
        // v1: all 255 -> 9*65025 mod 256 = 9
        v = '1;
        v.c = {8'd9, 8'd9, 8'd9, 8'd9};
        vecs[1] = v;
        // v2: A = 1..16, B all ones
        v = '0;
        for (int k = 0; k < 16; k++) v.a[k] = 8'(k + 1);
        for (int k = 0; k < 9; k++)  v.b[k] = 8'd1;
        v.c = {8'd99, 8'd90, 8'd63, 8'd54};
        vecs[2] = v;
        // v3: only b11 set -> C = A top-left 2x2 (detects kernel flip)
        for (int k = 0; k < 9; k++) v.b[k] = 8'd0;
        v.b[0] = 8'd1;
        v.c = {8'd6, 8'd5, 8'd2, 8'd1};
        vecs[3] = v;
        // v4: only b22 set -> C = A centre 2x2
        v.b[0] = 8'd0;
        v.b[4] = 8'd1;
        v.c = {8'd11, 8'd10, 8'd7, 8'd6};
        vecs[4] = v;

        for (int k = 0; k < 16; k++) a_p[k] = 8'h00;
        for (int k = 0; k < 9; k++)  b_p[k] = 8'h00;

        tick();
        tick();
        check("reset c", c_all, 32'd0);
        check("reset done", {28'd0, done_send, done_single, done_sa3, done_sa2}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            send_vec(vecs[i], c_all);
            for (int m = 0; m < 3; m++)
                run_mode(m, vecs[i].c, $sformatf("v%0d %s", i, mname[m]));
        end

        // Abort single at cycle 20: no done, c keeps v4 result; then a full restart
        send_vec(vecs[2], vecs[4].c);
        active_single = 1'b1;
        repeat (20) begin
            tick();
            check("abort no done", 32'(done_single), 32'd0);
        end
        active_single = 1'b0;
        tick();
        check("abort c kept", c_all, vecs[4].c);
        run_mode(0, vecs[2].c, "restart single");

        // single and sa2 both high: single wins, sa2 starts from zero once single drops
        send_vec(vecs[0], vecs[2].c);
        active_single = 1'b1;
        active_sa2    = 1'b1;
        repeat (36) tick();
        check("prio single done", 32'(done_single), 32'd1);
        check("prio sa2 held", 32'(done_sa2), 32'd0);
        check("prio result", c_all, vecs[0].c);
        active_single = 1'b0;
        repeat (27) tick();
        check("prio sa2 early", 32'(done_sa2), 32'd0);
        tick();
        check("prio sa2 done", 32'(done_sa2), 32'd1);
        check("prio sa2 result", c_all, vecs[0].c);
        active_sa2 = 1'b0;
        tick();

        // Reset mid-run of sa2 clears everything immediately
        send_vec(vecs[2], vecs[0].c);
        active_sa2 = 1'b1;
        repeat (10) tick();
        #2 rst = 1'b0;
        #1;
        check("midreset c", c_all, 32'd0);
        check("midreset done", {28'd0, done_send, done_single, done_sa3, done_sa2}, 32'd0);
        active_sa2 = 1'b0;
        #2 rst = 1'b1;
        tick();
        send_vec(vecs[3], 32'd0);
        run_mode(2, vecs[3].c, "post-reset sa2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
